// File: rtl/mod_select_seq.sv
// Sequential modulo-select unit: restoring divide a mod c, then
// z = (r == zero) ? c+1 : a-1, behind valid/ready handshakes.
module mod_select_seq #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] c,
    input  logic [DATAWIDTH-1:0] zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] z,
    output logic                 div0
);

    localparam int CW = (DATAWIDTH > 2) ? $clog2(DATAWIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATAWIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [DATAWIDTH-1:0] a_q, a_d;
    logic [DATAWIDTH-1:0] c_q, c_d;
    logic [DATAWIDTH-1:0] zero_q, zero_d;
    logic [DATAWIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATAWIDTH-1:0] z_q, z_d;
    logic                 div0_q, div0_d;

    logic [DATAWIDTH:0]   rem_shift;
    logic [DATAWIDTH:0]   rem_step;
    logic [DATAWIDTH-1:0] rem_final;
    logic [DATAWIDTH-1:0] z_sel;
    logic                 c_is_zero;

    // Remainder stays below c, so its top bit is always free for the shift.
    always_comb begin
        rem_shift = {rem_q[DATAWIDTH-1:0], a_q[cnt_q]};
        if (rem_shift >= {1'b0, c_q}) begin
            rem_step = rem_shift - {1'b0, c_q};
        end else begin
            rem_step = rem_shift;
        end
        c_is_zero = (c_q == '0);
        rem_final = c_is_zero ? a_q : rem_step[DATAWIDTH-1:0];
        if (rem_final == zero_q) begin
            z_sel = c_q + DATAWIDTH'(1);
        end else begin
            z_sel = a_q - DATAWIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        c_d     = c_q;
        zero_d  = zero_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        div0_d  = div0_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    c_d     = c;
                    zero_d  = zero;
                    rem_d   = '0;
                    cnt_d   = CNT_LAST;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                rem_d = rem_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    z_d     = z_sel;
                    div0_d  = c_is_zero;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            c_q     <= '0;
            zero_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            div0_q  <= div0_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign z         = z_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_mod_select_seq.sv
// Bench for mod_select_seq: 8-bit and 64-bit instances checked
// against an arithmetic reference model.
module tb_mod_select_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, d8;
    logic [7:0]  a8 = '0, c8 = '0, zr8 = '0, z8;
    logic        iv64 = 1'b0, ir64, ov64, or64 = 1'b0, d64;
    logic [63:0] a64 = '0, c64 = '0, zr64 = '0, z64;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mod_select_seq #(.DATAWIDTH(8)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .c(c8), .zero(zr8),
        .out_valid(ov8), .out_ready(or8),
        .z(z8), .div0(d8)
    );

    mod_select_seq #(.DATAWIDTH(64)) u64 (
        .clk(clk), .rst(rst),
        .in_valid(iv64), .in_ready(ir64),
        .a(a64), .c(c64), .zero(zr64),
        .out_valid(ov64), .out_ready(or64),
        .z(z64), .div0(d64)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: r = a mod c (a when c == 0), then select.
    function automatic logic [64:0] model(input bit w, input logic [63:0] ta,
                                          input logic [63:0] tc,
                                          input logic [63:0] tz);
        logic [63:0] m, r, zz;
        m  = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFF;
        ta = ta & m;
        tc = tc & m;
        tz = tz & m;
        r  = (tc == 0) ? ta : ta % tc;
        zz = (r == tz) ? tc + 1 : ta - 1;
        return {tc == 0, zz & m};
    endfunction

    function automatic logic ovl(input bit w);
        return w ? ov64 : ov8;
    endfunction

    function automatic logic rdy(input bit w);
        return w ? ir64 : ir8;
    endfunction

    function automatic logic [63:0] zout(input bit w);
        return w ? z64 : {56'd0, z8};
    endfunction

    function automatic logic dout(input bit w);
        return w ? d64 : d8;
    endfunction

    task automatic drive(input bit w, input logic v, input logic [63:0] ta,
                         input logic [63:0] tc, input logic [63:0] tz);
        if (w) begin
            iv64 = v; a64 = ta; c64 = tc; zr64 = tz;
        end else begin
            iv8 = v; a8 = ta[7:0]; c8 = tc[7:0]; zr8 = tz[7:0];
        end
    endtask

    task automatic set_ordy(input bit w, input logic v);
        if (w) or64 = v;
        else or8 = v;
    endtask

    // Called #1 after the accept edge; checks latency, result, handshake.
    task automatic wait_done(input bit w, input string tag,
                             input logic [64:0] exp, input int hold);
        int k;
        k = 0;
        while (!ovl(w) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, ".lat"}, 64'(k), w ? 64'd64 : 64'd8);
        check({tag, ".z"}, zout(w), exp[63:0]);
        check({tag, ".div0"}, 64'(dout(w)), 64'(exp[64]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_ov"}, 64'(ovl(w)), 64'd1);
        end
        set_ordy(w, 1'b1);
        @(posedge clk); #1;
        set_ordy(w, 1'b0);
        check({tag, ".ov_drop"}, 64'(ovl(w)), 64'd0);
    endtask

    task automatic txn(input bit w, input logic [63:0] ta,
                       input logic [63:0] tc, input logic [63:0] tz,
                       input int hold, input string tag);
        logic [64:0] exp;
        exp = model(w, ta, tc, tz);
        check({tag, ".rdy"}, 64'(rdy(w)), 64'd1);
        drive(w, 1'b1, ta, tc, tz);
        @(posedge clk); #1;
        drive(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom});
        wait_done(w, tag, exp, hold);
    endtask

    initial begin
        logic [63:0] ra, rc, rz;
        logic [64:0] e;
        #3;
        check("rst.z", zout(0), 64'd0);
        check("rst.ov", 64'(ov8), 64'd0);
        check("rst.rdy", 64'(ir8), 64'd1);
        check("rst.div0", 64'(d8), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        txn(0, 10, 5, 0, 0, "d8_10_5");
        txn(0, 10, 3, 0, 1, "d8_10_3");
        txn(0, 0, 7, 5, 0, "d8_wrap_dec");
        txn(0, 255, 255, 0, 2, "d8_wrap_inc");
        txn(0, 7, 0, 7, 0, "d8_div0_match");
        txn(0, 7, 0, 3, 0, "d8_div0_miss");
        txn(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000,
            64'hFFFF_FFFF, 0, "d64_big");

        // Backpressure: held result, new operands must wait.
        check("bp.rdy", 64'(ir8), 64'd1);
        drive(0, 1'b1, 20, 6, 2);
        @(posedge clk); #1;
        drive(0, 1'b0, 0, 0, 0);
        while (!ov8) begin
            @(posedge clk); #1;
        end
        drive(0, 1'b1, 50, 7, 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp.ov", 64'(ov8), 64'd1);
            check("bp.z", zout(0), 64'd7);
            check("bp.rdy_lo", 64'(ir8), 64'd0);
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check("bp.ov_drop", 64'(ov8), 64'd0);
        check("bp.idle_rdy", 64'(ir8), 64'd1);
        @(posedge clk); #1;
        check("bp.accepted", 64'(ir8), 64'd0);
        drive(0, 1'b0, 0, 0, 0);
        wait_done(0, "bp.held", model(0, 50, 7, 1), 0);

        // Reset in the middle of a calculation.
        txn(0, 10, 3, 0, 0, "pre_rst");
        drive(0, 1'b1, 200, 13, 5);
        @(posedge clk); #1;
        drive(0, 1'b0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst.ov", 64'(ov8), 64'd0);
        check("mid_rst.z", zout(0), 64'd0);
        check("mid_rst.rdy", 64'(ir8), 64'd1);
        check("mid_rst.div0", 64'(d8), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        txn(0, 9, 4, 1, 0, "post_rst");

        for (int i = 0; i < 40; i++) begin
            ra = 64'($urandom_range(255));
            rc = (i % 7 == 0) ? 64'd0 : 64'($urandom_range(255));
            e  = model(0, ra, rc, 0);
            rz = $urandom_range(1) ? ((rc == 0) ? ra : ra % rc)
                                   : 64'($urandom_range(255));
            repeat ($urandom_range(2)) begin
                @(posedge clk); #1;
            end
            txn(0, ra, rc, rz, $urandom_range(3), "rnd8");
        end
        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom};
            rc = (i == 3) ? 64'd0 : (i % 2 == 0) ? 64'($urandom_range(1000))
                                                 : {$urandom, $urandom};
            rz = $urandom_range(1) ? ((rc == 0) ? ra : ra % rc)
                                   : {$urandom, $urandom};
            txn(1, ra, rc, rz, $urandom_range(2), "rnd64");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
